// File: rtl/oled_spi_sink_pkg.sv
// Shared types and constants for the OLED SPI receive path.
package oled_spi_sink_pkg;

   localparam logic OLED_DC_CMD  = 1'b0;
   localparam logic OLED_DC_DATA = 1'b1;

   // One received byte tagged with its dc level
   typedef struct packed {
      logic       dc;
      logic [7:0] data;
   } oled_byte_t;

   localparam int unsigned OLED_BYTE_W = $bits(oled_byte_t);
   localparam int unsigned BIT_CNT_W   = 3;
   localparam int unsigned COUNT_W     = 16;

   // Receiver states: IDLE while deselected or panel held in reset
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } rx_state_t;

endpackage

// File: rtl/oled_spi_sink_if.sv
// Drain-side handshake of the OLED SPI sink: head-of-FIFO byte with valid/ready.
interface oled_spi_sink_if;

   logic [7:0] byte_data;
   logic       byte_is_data;
   logic       byte_valid;
   logic       byte_ready;

   // Producer side (the sink)
   modport master (
      output byte_data,
      output byte_is_data,
      output byte_valid,
      input  byte_ready
   );

   // Consumer side
   modport slave (
      input  byte_data,
      input  byte_is_data,
      input  byte_valid,
      output byte_ready
   );

endinterface

// File: rtl/oled_spi_sink_sync_fifo.sv
// Small synchronous FIFO with a registered head word and registered full/empty.
module oled_spi_sink_sync_fifo #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    wr_ptr_n;
   logic [AW-1:0]    rd_ptr_n;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_n;
   logic [WIDTH-1:0] rdata_n;
   logic             pop_ok;
   logic             push_ok;

   // Next pointers/count and the word that will sit at the head next cycle
   always_comb begin
      pop_ok   = pop & ~empty;
      push_ok  = push & (~full | pop_ok);
      wr_ptr_n = wr_ptr_q + AW'(push_ok);
      rd_ptr_n = rd_ptr_q + AW'(pop_ok);
      count_n  = count_q + CW'(push_ok) - CW'(pop_ok);
      rdata_n  = rdata;
      // Incoming word becomes the head when it lands in the slot being exposed
      if (push_ok && (rd_ptr_n == wr_ptr_q)) begin
         rdata_n = wdata;
      end else if (count_n != '0) begin
         rdata_n = mem_q[rd_ptr_n];
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointers, occupancy and registered head/flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_n;
         rd_ptr_q <= rd_ptr_n;
         count_q  <= count_n;
         rdata    <= rdata_n;
         full     <= (count_n == CW'(DEPTH));
         empty    <= (count_n == '0);
      end
   end

endmodule

// File: rtl/oled_spi_sink.sv
// OLED SPI receiver: oversamples sck/mosi/dc/cs, assembles mode-0 MSB-first bytes
// tagged command/data and queues them for a valid/ready consumer.
module oled_spi_sink
   import oled_spi_sink_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sck,
   input  logic                mosi,
   input  logic                dc_in,
   input  logic                cs,
   input  logic                reset_oled,
   oled_spi_sink_if.master     drain,
   output logic                overflow,
   output logic                frame_error,
   output logic [COUNT_W-1:0]  byte_count
);

   // Pin bundle order: {cs, reset_oled, sck, mosi, dc}; cs and reset_oled idle high
   localparam int unsigned     PIN_W    = 5;
   localparam logic [PIN_W-1:0] SYNC_RST = 5'b11000;

   logic [PIN_W-1:0]                  pins;
   logic [SYNC_STAGES-1:0][PIN_W-1:0] sync_q;
   logic cs_s;
   logic reset_oled_s;
   logic sck_s;
   logic mosi_s;
   logic dc_s;

   logic sck_d_q;
   logic cs_d_q;
   logic sck_rise;
   logic cs_fall;

   rx_state_t            state_q;
   rx_state_t            state_n;
   logic [BIT_CNT_W-1:0] bit_cnt_q;
   logic [BIT_CNT_W-1:0] bit_cnt_n;
   logic [7:0]           shift_q;
   logic [7:0]           shift_n;
   logic                 push_q;
   logic                 push_n;
   oled_byte_t           push_data_q;
   oled_byte_t           push_data_n;
   logic                 frame_err_n;

   oled_byte_t head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;

   assign pins = {cs, reset_oled, sck, mosi, dc_in};

   // Multi-flop synchronizers for every SPI pin
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{SYNC_RST}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      end
   end

   assign cs_s         = sync_q[SYNC_STAGES-1][4];
   assign reset_oled_s = sync_q[SYNC_STAGES-1][3];
   assign sck_s        = sync_q[SYNC_STAGES-1][2];
   assign mosi_s       = sync_q[SYNC_STAGES-1][1];
   assign dc_s         = sync_q[SYNC_STAGES-1][0];

   assign sck_rise = sck_s & ~sck_d_q;
   assign cs_fall  = cs_d_q & ~cs_s;
   assign pop      = ~fifo_empty & drain.byte_ready;

   // Receiver FSM: frame entry/exit, bit assembly and byte completion
   always_comb begin
      state_n     = state_q;
      bit_cnt_n   = bit_cnt_q;
      shift_n     = shift_q;
      push_n      = 1'b0;
      push_data_n = push_data_q;
      frame_err_n = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall && reset_oled_s) begin
               state_n   = ST_SHIFT;
               bit_cnt_n = '0;
               shift_n   = '0;
            end
         end
         ST_SHIFT: begin
            if (!reset_oled_s) begin
               // Panel reset silently abandons any partial byte
               state_n   = ST_IDLE;
               bit_cnt_n = '0;
               shift_n   = '0;
            end else if (cs_s) begin
               // Deselect wins over a coincident sck edge
               state_n     = ST_IDLE;
               frame_err_n = (bit_cnt_q != '0);
               bit_cnt_n   = '0;
               shift_n     = '0;
            end else if (sck_rise) begin
               shift_n = {shift_q[6:0], mosi_s};
               if (bit_cnt_q == BIT_CNT_W'(7)) begin
                  push_n           = 1'b1;
                  push_data_n.dc   = dc_s;
                  push_data_n.data = {shift_q[6:0], mosi_s};
                  bit_cnt_n        = '0;
               end else begin
                  bit_cnt_n = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // State, datapath and status registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_IDLE;
         bit_cnt_q        <= '0;
         shift_q          <= '0;
         push_q           <= 1'b0;
         push_data_q.dc   <= OLED_DC_CMD;
         push_data_q.data <= '0;
         sck_d_q          <= 1'b0;
         cs_d_q           <= 1'b1;
         frame_error      <= 1'b0;
         overflow         <= 1'b0;
         byte_count       <= '0;
      end else begin
         state_q     <= state_n;
         bit_cnt_q   <= bit_cnt_n;
         shift_q     <= shift_n;
         push_q      <= push_n;
         push_data_q <= push_data_n;
         sck_d_q     <= sck_s;
         cs_d_q      <= cs_s;
         frame_error <= frame_err_n;
         if (push_q) begin
            byte_count <= byte_count + COUNT_W'(1);
         end
         if (push_q && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Byte buffer between the receiver and the consumer
   oled_spi_sink_sync_fifo #(
      .WIDTH (OLED_BYTE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push_q),
      .wdata   (push_data_q),
      .pop     (pop),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign drain.byte_data    = head.data;
   assign drain.byte_is_data = (head.dc == OLED_DC_DATA);
   assign drain.byte_valid   = ~fifo_empty;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: bit-banged SPI frames against a queue model.
module tb_oled_spi_sink;

   logic        clk        = 1'b0;
   logic        reset_n    = 1'b0;
   logic        sck        = 1'b0;
   logic        mosi       = 1'b0;
   logic        dc_in      = 1'b0;
   logic        cs         = 1'b1;
   logic        reset_oled = 1'b1;
   logic        overflow;
   logic        frame_error;
   logic [15:0] byte_count;

   oled_spi_sink_if drain_if ();

   oled_spi_sink #(
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sck         (sck),
      .mosi        (mosi),
      .dc_in       (dc_in),
      .cs          (cs),
      .reset_oled  (reset_oled),
      .drain       (drain_if),
      .overflow    (overflow),
      .frame_error (frame_error),
      .byte_count  (byte_count)
   );

   always #5 clk = ~clk;

   // Reference model: expected FIFO contents, byte count, sticky overflow, error pulses
   logic [8:0]  exp_q[$];
   logic [15:0] exp_cnt = '0;
   logic        exp_ov  = 1'b0;
   int          exp_fe  = 0;
   int          fe_cnt  = 0;
   int          n_cmp   = 0;
   int          n_err   = 0;

   // Count every cycle frame_error is high; a correct pulse adds exactly one
   always @(posedge clk) if (frame_error === 1'b1) fe_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_push(input logic [8:0] e);
      exp_cnt = exp_cnt + 16'd1;
      if (exp_q.size() < 4) exp_q.push_back(e);
      else exp_ov = 1'b1;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check({tag, "_rst_valid"}, 32'(drain_if.byte_valid), 32'(0));
      check({tag, "_rst_data"},  32'(drain_if.byte_data), 32'(0));
      check({tag, "_rst_isdat"}, 32'(drain_if.byte_is_data), 32'(0));
      check({tag, "_rst_ovf"},   32'(overflow), 32'(0));
      check({tag, "_rst_ferr"},  32'(frame_error), 32'(0));
      check({tag, "_rst_cnt"},   32'(byte_count), 32'(0));
      exp_q.delete();
      exp_cnt = '0;
      exp_ov  = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   // Drive n bits of v MSB first; optionally pulse byte_ready on the cycle the 8th bit's byte is pushed
   task automatic spi_bits(input logic [7:0] v, input int n, input logic dc, input bit pop_at_push);
      for (int i = 0; i < n; i++) begin
         mosi  = v[7-i];
         dc_in = dc;
         repeat ($urandom_range(2, 4)) @(negedge clk);
         sck = 1'b1;
         if (pop_at_push && i == 7) begin
            repeat (3) @(negedge clk);
            check("pop_head", 32'({drain_if.byte_is_data, drain_if.byte_data}), 32'(exp_q[0]));
            drain_if.byte_ready = 1'b1;
            void'(exp_q.pop_front());
            @(negedge clk);
            drain_if.byte_ready = 1'b0;
            @(negedge clk);
         end else begin
            repeat ($urandom_range(2, 4)) @(negedge clk);
         end
         sck = 1'b0;
      end
      if (n == 8) model_push({dc, v});
   endtask

   task automatic cs_begin();
      cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_cnt"},  32'(byte_count), 32'(exp_cnt));
      check({tag, "_ovf"},  32'(overflow), 32'(exp_ov));
      check({tag, "_ferr"}, 32'(fe_cnt), 32'(exp_fe));
   endtask

   task automatic drain_all(input string tag);
      while (exp_q.size() > 0) begin
         check({tag, "_valid"}, 32'(drain_if.byte_valid), 32'(1));
         check({tag, "_entry"}, 32'({drain_if.byte_is_data, drain_if.byte_data}), 32'(exp_q.pop_front()));
         drain_if.byte_ready = 1'b1;
         @(negedge clk);
         drain_if.byte_ready = 1'b0;
      end
      check({tag, "_empty"}, 32'(drain_if.byte_valid), 32'(0));
   endtask

   initial begin
      int nb;
      int np;
      drain_if.byte_ready = 1'b0;
      do_reset("init");

      // Single command byte
      cs_begin();
      spi_bits(8'hAE, 8, 1'b0, 1'b0);
      cs_end();
      check_status("cmd");
      drain_all("cmd");

      // Multi-byte data frame under one cs
      cs_begin();
      spi_bits(8'h12, 8, 1'b1, 1'b0);
      spi_bits(8'h34, 8, 1'b1, 1'b0);
      spi_bits(8'h56, 8, 1'b1, 1'b0);
      cs_end();
      check_status("data3");
      drain_all("data3");

      // Partial byte then deselect
      cs_begin();
      spi_bits(8'hA5, 5, 1'b1, 1'b0);
      cs_end();
      exp_fe++;
      check_status("partial");
      drain_all("partial");

      // Overflow with consumer stalled
      cs_begin();
      for (int k = 0; k < 5; k++) spi_bits(8'($urandom), 8, 1'($urandom), 1'b0);
      cs_end();
      check_status("ovf");
      drain_all("ovf");
      do_reset("clr_ovf");

      // Full FIFO with a pop coinciding with the 5th push
      cs_begin();
      for (int k = 0; k < 4; k++) spi_bits(8'($urandom), 8, 1'($urandom), 1'b0);
      spi_bits(8'($urandom), 8, 1'($urandom), 1'b1);
      cs_end();
      check_status("fullpop");
      drain_all("fullpop");

      // Panel reset mid-byte: partial dropped silently, earlier byte kept
      cs_begin();
      spi_bits(8'h11, 8, 1'b1, 1'b0);
      spi_bits(8'hFF, 3, 1'b1, 1'b0);
      reset_oled = 1'b0;
      repeat (4) @(negedge clk);
      reset_oled = 1'b1;
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
      check_status("oledrst");
      cs_begin();
      spi_bits(8'h5A, 8, 1'b1, 1'b0);
      cs_end();
      check_status("oledrst_5a");
      drain_all("oledrst");

      // Randomized frames: 0..3 whole bytes followed by 0..7 trailing bits
      for (int t = 0; t < 12; t++) begin
         nb = int'($urandom_range(0, 3));
         np = int'($urandom_range(0, 7));
         cs_begin();
         for (int k = 0; k < nb; k++) spi_bits(8'($urandom), 8, 1'($urandom), 1'b0);
         if (np != 0) begin
            spi_bits(8'($urandom), np, 1'($urandom), 1'b0);
            exp_fe++;
         end
         cs_end();
         check_status("rand");
         drain_all("rand");
      end

      // System reset mid-byte with cs held low: receiver re-arms from the synchronized cs
      cs_begin();
      spi_bits(8'h00, 3, 1'b0, 1'b0);
      do_reset("midrst");
      repeat (4) @(negedge clk);
      spi_bits(8'hC3, 8, 1'b1, 1'b0);
      cs_end();
      check_status("midrst");
      drain_all("midrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
